// File: rtl/pe_lane_mac.sv
// Systolic processing element for the dmme matrix engine.
// Forwards A/B/mask operands one register stage to its neighbours and computes a
// LANES-wide signed dot product (dense or mask-gated sparse) through a 2-stage pipeline.
// SHIFT drains the accumulator to o_c_out and loads i_cin in the same edge.
// Optional build macro: PE_SAT_EN -- accumulator additions saturate instead of wrapping.
module pe_lane_mac #(
  parameter int unsigned LANES = 4,
  parameter int unsigned A_W   = 16,
  parameter int unsigned B_W   = 8,
  parameter int unsigned ACC_W = 32
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_en,
  input  logic                   i_clr,
  input  logic [1:0]             i_mode,
  input  logic [LANES-1:0]       i_maskin,
  input  logic [LANES*A_W-1:0]   i_ain,
  input  logic [LANES*B_W-1:0]   i_bin,
  input  logic [ACC_W-1:0]       i_cin,
  output logic [LANES-1:0]       o_mask_out,
  output logic [LANES*A_W-1:0]   o_a_out,
  output logic [LANES*B_W-1:0]   o_b_out,
  output logic [ACC_W-1:0]       o_c_out,
  output logic                   o_cvalid,
  output logic                   o_ovf
);

  typedef enum logic [1:0] {
    ModeDense  = 2'b00,
    ModeSparse = 2'b01,
    ModeShift  = 2'b10,
    ModeWait   = 2'b11
  } mode_e;

  localparam int unsigned P_W = A_W + B_W;
  localparam logic [ACC_W-1:0] AccMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] AccMin = {1'b1, {(ACC_W-1){1'b0}}};

  mode_e w_mode;
  assign w_mode = mode_e'(i_mode);

  logic [LANES-1:0]     r_mask_out;
  logic [LANES*A_W-1:0] r_a_out;
  logic [LANES*B_W-1:0] r_b_out;
  logic [ACC_W-1:0]     r_c_out;
  logic                 r_cvalid;
  logic                 r_ovf;
  logic [ACC_W-1:0]     r_acc;
  logic [ACC_W-1:0]     r_psum;
  logic                 r_psum_v;

  logic signed [P_W-1:0]   w_prod [LANES];
  logic signed [ACC_W-1:0] w_prod_ext [LANES];
  logic [ACC_W-1:0]        w_sum;
  logic [ACC_W-1:0]        w_add_b;
  logic [ACC_W-1:0]        w_add_raw;
  logic                    w_add_ovf;
  logic [ACC_W-1:0]        w_add_res;
  logic                    w_is_product;

  assign w_is_product = (w_mode == ModeDense) || (w_mode == ModeSparse);

  // Stage-1 dot product: sign-extended lane products, sparse lanes gated by the mask
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_prod[i] = P_W'($signed(i_ain[i*A_W +: A_W])) * P_W'($signed(i_bin[i*B_W +: B_W]));
      w_prod_ext[i] = ACC_W'(w_prod[i]);
      if (w_mode == ModeDense || i_maskin[i]) begin
        w_sum = w_sum + w_prod_ext[i];
      end
    end
  end

  // Shared commit adder: stage-2 accumulate and SHIFT drain both add the pending psum to acc
  always_comb begin
    w_add_b   = r_psum_v ? r_psum : '0;
    w_add_raw = r_acc + w_add_b;
    w_add_ovf = (r_acc[ACC_W-1] == w_add_b[ACC_W-1]) &&
                (w_add_raw[ACC_W-1] != r_acc[ACC_W-1]);
`ifdef PE_SAT_EN
    w_add_res = w_add_ovf ? (r_acc[ACC_W-1] ? AccMin : AccMax) : w_add_raw;
`else
    w_add_res = w_add_raw;
`endif
  end

  // Operand forwarding to neighbouring PEs, independent of mode
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_mask_out <= '0;
      r_a_out    <= '0;
      r_b_out    <= '0;
    end else if (i_en) begin
      r_mask_out <= i_maskin;
      r_a_out    <= i_ain;
      r_b_out    <= i_bin;
    end
  end

  // Accumulate pipeline, drain and overflow tracking
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_c_out  <= '0;
      r_cvalid <= 1'b0;
      r_ovf    <= 1'b0;
      r_acc    <= '0;
      r_psum   <= '0;
      r_psum_v <= 1'b0;
    end else if (!i_en) begin
      r_cvalid <= 1'b0;
    end else if (w_mode == ModeShift) begin
      // In-flight psum is folded into the drained value so it is never lost
      r_c_out  <= w_add_res;
      r_acc    <= i_cin;
      r_psum_v <= 1'b0;
      r_cvalid <= 1'b1;
      r_ovf    <= i_clr ? 1'b0 : (r_ovf | w_add_ovf);
    end else begin
      r_cvalid <= 1'b0;
      if (i_clr) begin
        r_acc    <= '0;
        r_psum_v <= 1'b0;
        r_ovf    <= 1'b0;
      end else begin
        if (r_psum_v) begin
          r_acc <= w_add_res;
          if (w_add_ovf) r_ovf <= 1'b1;
        end
        if (w_is_product) begin
          r_psum   <= w_sum;
          r_psum_v <= 1'b1;
        end else begin
          r_psum_v <= 1'b0;
        end
      end
    end
  end

  assign o_mask_out = r_mask_out;
  assign o_a_out    = r_a_out;
  assign o_b_out    = r_b_out;
  assign o_c_out    = r_c_out;
  assign o_cvalid   = r_cvalid;
  assign o_ovf      = r_ovf;

endmodule

// File: tb/tb_pe_lane_mac.sv
// Self-checking bench for pe_lane_mac (LANES=4, A_W=16, B_W=8, ACC_W=32).
// A behavioural model over plain integers tracks acc, the pending dot product and
// the drained value; a negedge process compares every output against it.
// Directed scenarios pin the model with hand-computed values, then random traffic runs.
module tb_pe_lane_mac;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        clr = 1'b0;
  logic [1:0]  mode = 2'd3;
  logic [3:0]  mask = '0;
  logic [63:0] ain = '0;
  logic [31:0] bin = '0;
  logic [31:0] cin = '0;
  logic [3:0]  mask_out;
  logic [63:0] a_out;
  logic [31:0] b_out;
  logic [31:0] c_out;
  logic        cvalid;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] DENSE = 2'd0, SPARSE = 2'd1, SHIFT = 2'd2, WAITM = 2'd3;
  localparam logic [63:0] A1 = {16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [31:0] B1 = {8'd8, 8'd7, 8'd6, 8'd5};

  pe_lane_mac #(.LANES(4), .A_W(16), .B_W(8), .ACC_W(32)) dut (
    .i_clock(clk), .i_reset(rst), .i_en(en), .i_clr(clr), .i_mode(mode),
    .i_maskin(mask), .i_ain(ain), .i_bin(bin), .i_cin(cin),
    .o_mask_out(mask_out), .o_a_out(a_out), .o_b_out(b_out), .o_c_out(c_out),
    .o_cvalid(cvalid), .o_ovf(ovf)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [3:0]  m_mask;
  logic [63:0] m_a;
  logic [31:0] m_b;
  logic [31:0] m_cout;
  logic        m_cv;
  logic        m_ovf;
  longint      m_acc;
  longint      m_psum;
  logic        m_pv;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  function automatic logic oor(input longint t);
    return (t > MAXV) || (t < MINV);
  endfunction

  function automatic longint fit(input longint t);
    logic [63:0] u;
`ifdef PE_SAT_EN
    if (t > MAXV) return MAXV;
    if (t < MINV) return MINV;
    return t;
`else
    u = t;
    return longint'($signed(u[31:0]));
`endif
  endfunction

  function automatic longint lane_prod(input logic [63:0] a, input logic [31:0] b, input int i);
    return longint'($signed(a[i*16 +: 16])) * longint'($signed(b[i*8 +: 8]));
  endfunction

  always @(posedge clk or posedge rst) begin : model
    longint s;
    longint t;
    logic [63:0] tv;
    if (rst) begin
      m_mask <= '0; m_a <= '0; m_b <= '0; m_cout <= '0; m_cv <= 1'b0; m_ovf <= 1'b0;
      m_acc <= 0; m_psum <= 0; m_pv <= 1'b0;
    end else if (en) begin
      m_mask <= mask; m_a <= ain; m_b <= bin;
      s = 0;
      for (int i = 0; i < 4; i++)
        if (mode == DENSE || (mode == SPARSE && mask[i])) s = s + lane_prod(ain, bin, i);
      if (mode == SHIFT) begin
        t = m_acc + (m_pv ? m_psum : 0);
        tv = fit(t);
        m_cout <= tv[31:0];
        m_acc  <= longint'($signed(cin));
        m_pv   <= 1'b0;
        m_cv   <= 1'b1;
        m_ovf  <= clr ? 1'b0 : (m_ovf | oor(t));
      end else begin
        m_cv <= 1'b0;
        if (clr) begin
          m_acc <= 0; m_pv <= 1'b0; m_ovf <= 1'b0;
        end else begin
          if (m_pv) begin
            t = m_acc + m_psum;
            m_acc <= fit(t);
            if (oor(t)) m_ovf <= 1'b1;
          end
          if (mode == DENSE || mode == SPARSE) begin
            m_psum <= s; m_pv <= 1'b1;
          end else begin
            m_pv <= 1'b0;
          end
        end
      end
    end else begin
      m_cv <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every output compared against the model away from the active edge
  always @(negedge clk) begin
    chk("maskOut", {60'd0, mask_out}, {60'd0, m_mask});
    chk("aOut", a_out, m_a);
    chk("bOut", {32'd0, b_out}, {32'd0, m_b});
    chk("cOut", {32'd0, c_out}, {32'd0, m_cout});
    chk("cvalid", {63'd0, cvalid}, {63'd0, m_cv});
    chk("ovf", {63'd0, ovf}, {63'd0, m_ovf});
  end

  // Apply one cycle of inputs; returns 1 time unit after the edge that consumes them
  task automatic step(input logic [1:0] md, input logic [3:0] mk, input logic [63:0] a,
                      input logic [31:0] b, input logic [31:0] c, input logic e,
                      input logic cl);
    mode = md; mask = mk; ain = a; bin = b; cin = c; en = e; clr = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [1:0] md, input logic [31:0] c);
    step(md, 4'h0, 64'd0, 32'd0, c, 1'b1, 1'b0);
  endtask

  logic [31:0] exp5;

  initial begin
    // Reset state while reset is held
    #3;
    chk("rst_cOut", {32'd0, c_out}, 64'd0);
    chk("rst_cvalid", {63'd0, cvalid}, 64'd0);
    chk("rst_aOut", a_out, 64'd0);
    #9 rst = 1'b0;

    // 1: dense dot product, drained after two waits
    step(DENSE, 4'h0, A1, B1, 32'd0, 1'b1, 1'b0);
    idle(WAITM, 32'd0);
    idle(WAITM, 32'd0);
    idle(SHIFT, 32'd0);
    chk("t1_cOut", {32'd0, c_out}, 64'd70);
    chk("t1_cvalid_hi", {63'd0, cvalid}, 64'd1);
    idle(WAITM, 32'd0);
    chk("t1_cvalid_lo", {63'd0, cvalid}, 64'd0);

    // 2: sparse, lanes 0 and 2
    step(SPARSE, 4'b0101, A1, B1, 32'd0, 1'b1, 1'b0);
    chk("t2_maskOut", {60'd0, mask_out}, 64'b0101);
    idle(WAITM, 32'd0);
    idle(SHIFT, 32'd0);
    chk("t2_cOut", {32'd0, c_out}, 64'd26);

    // 3: in-flight product committed by SHIFT, acc loaded from cin
    step(DENSE, 4'h0, A1, B1, 32'd0, 1'b1, 1'b0);
    step(DENSE, 4'h0, A1, B1, 32'd0, 1'b1, 1'b0);
    idle(SHIFT, 32'h11);
    chk("t3_cOut", {32'd0, c_out}, 64'd140);
    idle(SHIFT, 32'd0);
    chk("t3_acc_eq_cin", {32'd0, c_out}, 64'h11);

    // 4: signed lane-0 products
    step(DENSE, 4'h0, 64'hFFFD, 32'hFE, 32'd0, 1'b1, 1'b0);
    idle(WAITM, 32'd0);
    idle(SHIFT, 32'd0);
    chk("t4_pos", {32'd0, c_out}, 64'd6);
    step(DENSE, 4'h0, 64'h8000, 32'h7F, 32'd0, 1'b1, 1'b0);
    idle(WAITM, 32'd0);
    idle(SHIFT, 32'd0);
    chk("t4_neg", {32'd0, c_out}, 64'hFFC08000);

    // 5: accumulator overflow
    idle(SHIFT, 32'h7FFFFFF0);
    step(DENSE, 4'h0, A1, B1, 32'd0, 1'b1, 1'b0);
    idle(WAITM, 32'd0);
    idle(SHIFT, 32'd0);
`ifdef PE_SAT_EN
    exp5 = 32'h7FFFFFFF;
`else
    exp5 = 32'h80000036;
`endif
    chk("t5_cOut", {32'd0, c_out}, {32'd0, exp5});
    chk("t5_ovf", {63'd0, ovf}, 64'd1);
    step(WAITM, 4'h0, 64'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    chk("t5_ovf_clr", {63'd0, ovf}, 64'd0);

    // 6: freeze mid-accumulation, then drain
    step(DENSE, 4'hF, A1, B1, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(DENSE, 4'h3, 64'h1234, 32'h55, 32'd9, 1'b0, 1'b0);
    chk("t6_aOut_frozen", a_out, A1);
    chk("t6_maskOut_frozen", {60'd0, mask_out}, 64'hF);
    idle(WAITM, 32'd0);
    idle(SHIFT, 32'd0);
    chk("t6_cOut", {32'd0, c_out}, 64'd70);

    // Async reset pulse while cvalid is high
    #2 rst = 1'b1;
    #1;
    chk("rst_async_cvalid", {63'd0, cvalid}, 64'd0);
    chk("rst_async_cOut", {32'd0, c_out}, 64'd0);
    chk("rst_async_aOut", a_out, 64'd0);
    #1 rst = 1'b0;

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      step(2'($urandom_range(0, 3)), 4'($urandom), {$urandom, $urandom}, $urandom,
           ($urandom_range(0, 3) == 0) ? 32'h7FFFFF00 + 32'($urandom_range(0, 255)) : $urandom,
           ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0));
    end
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
